// File: rtl/buzz_pkg.sv
// Shared definitions for the key-beep player: FSM encoding, key codes,
// counter widths and the default tone half-period table.
package buzz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int DUR_W  = 23;
    localparam int TONE_W = 15;
    localparam int REM_W  = 3;

    localparam logic [2:0] KEY_1 = 3'd1;
    localparam logic [2:0] KEY_2 = 3'd2;
    localparam logic [2:0] KEY_3 = 3'd3;
    localparam logic [2:0] KEY_4 = 3'd4;

    // Half-periods at 50 MHz for 1 / 1.5 / 2 / 2.5 kHz.
    localparam int TONE1_HALF_DEF = 25_000;
    localparam int TONE2_HALF_DEF = 16_667;
    localparam int TONE3_HALF_DEF = 12_500;
    localparam int TONE4_HALF_DEF = 10_000;

    function automatic logic is_valid_key(input logic [2:0] key);
        return (key >= KEY_1) && (key <= KEY_4);
    endfunction

endpackage

// File: rtl/buzz_player_tone_gen.sv
// Square-wave generator: while enabled, toggles wave every `half` cycles;
// when disabled, the counter and the wave are parked at 0.
module tone_gen
    import buzz_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [TONE_W-1:0] half,
    output logic              wave
);

    logic [TONE_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt == half - TONE_W'(1)) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt  <= cnt + TONE_W'(1);
        end
    end

endmodule

// File: rtl/buzz_player.sv
// Key-feedback beeper: a valid key code k plays k beeps of tone k, each
// followed by a silent gap; a new valid code restarts the sequence at once.
module buzz_player
    import buzz_pkg::*;
#(
    parameter int unsigned BEEP_MAX   = 4_999_999,
    parameter int unsigned GAP_MAX    = 4_999_999,
    parameter int unsigned TONE1_HALF = TONE1_HALF_DEF,
    parameter int unsigned TONE2_HALF = TONE2_HALF_DEF,
    parameter int unsigned TONE3_HALF = TONE3_HALF_DEF,
    parameter int unsigned TONE4_HALF = TONE4_HALF_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_val,
    output logic       buzz,
    output logic       busy,
    output logic       done
);

    localparam logic [DUR_W-1:0] BEEP_LIM = DUR_W'(BEEP_MAX);
    localparam logic [DUR_W-1:0] GAP_LIM  = DUR_W'(GAP_MAX);

    state_t             state, state_next;
    logic [DUR_W-1:0]   dur, dur_next;
    logic [REM_W-1:0]   rem, rem_next;
    logic [2:0]         code, code_next;
    logic               done_next;
    logic               restart;
    logic               tone_run;
    logic [TONE_W-1:0]  half;

    // NOTE: every always_comb output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        dur_next   = dur;
        rem_next   = rem;
        code_next  = code;
        done_next  = 1'b0;
        restart    = is_valid_key(key_val);

        if (restart) begin
            state_next = ST_ON;
            dur_next   = '0;
            rem_next   = key_val;
            code_next  = key_val;
        end else begin
            unique case (state)
                ST_ON: begin
                    if (dur == BEEP_LIM) begin
                        state_next = ST_OFF;
                        dur_next   = '0;
                        rem_next   = rem - REM_W'(1);
                    end else begin
                        dur_next   = dur + DUR_W'(1);
                    end
                end
                ST_OFF: begin
                    if (dur == GAP_LIM) begin
                        dur_next = '0;
                        if (rem == '0) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_ON;
                        end
                    end else begin
                        dur_next = dur + DUR_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    dur_next   = '0;
                end
            endcase
        end

        // Tone only advances between two ON cycles of the same beep, so each
        // beep (and each restart) starts from a low wave and a zero counter.
        tone_run = (state == ST_ON) && (state_next == ST_ON) && !restart;

        unique case (code)
            KEY_2:   half = TONE_W'(TONE2_HALF);
            KEY_3:   half = TONE_W'(TONE3_HALF);
            KEY_4:   half = TONE_W'(TONE4_HALF);
            default: half = TONE_W'(TONE1_HALF);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            dur   <= '0;
            rem   <= '0;
            code  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            dur   <= dur_next;
            rem   <= rem_next;
            code  <= code_next;
            busy  <= (state_next != ST_IDLE);
            done  <= done_next;
        end
    end

    tone_gen u_tone_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (tone_run),
        .half   (half),
        .wave   (buzz)
    );

endmodule
